mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 i_req  input  1  fetch-port request; held until i_ack or withdrawn.
REQ-004 i_addr  input  32  fetch address; read-only port, word width (2'b10), no extend.
REQ-005 i_ack  output  1  fetch-port completion; i_rdata valid this cycle.
REQ-006 i_rdata  output  32  fetch read data.
REQ-007 d_req  input  1  data-port request from the memory stage.
REQ-008 d_addr, d_wdata  input  32 each  data-port address and write data.
REQ-009 d_write, d_extend  input  1 each  store select; sign-extend select.
REQ-010 d_width  input  2  access width: 0 byte, 1 half, 2 word.
REQ-011 d_ack  output  1  data-port completion; d_rdata valid this cycle.
REQ-012 d_rdata  output  32  data read data.
REQ-013 m_req, m_write, m_extend  output  1 each  shared memory request and attributes.
REQ-014 m_addr, m_wdata  output  32 each  shared memory address and write data.
REQ-015 m_width  output  2  shared memory width.
REQ-016 m_ack  input  1  memory completion; m_rdata valid same cycle.
REQ-017 m_rdata  input  32  memory read data.

Function
REQ-018 The block SHALL hold a registered state IDLE, GNT_I, or GNT_D, plus a 1-bit register last (0 = fetch, 1 = data) naming the most recently completed grant.
REQ-019 In IDLE, the block SHALL drive m_req = 0 and both acks = 0.
REQ-020 In GNT_X, m_req SHALL equal X_req combinationally, and m_addr/m_write/m_wdata/m_extend/m_width SHALL come from port X (fetch: write 0, wdata 0, extend 0, width 2'b10).
REQ-021 X_ack SHALL equal m_ack only while in GNT_X; the other port's ack SHALL be 0.
REQ-022 i_rdata and d_rdata SHALL both equal m_rdata unconditionally.
REQ-023 Next-grant selection, used in IDLE and in any cycle where the current grant ends:
  - only one request pending -> grant that port;
  - both pending -> grant the port not equal to last (round-robin);
  - none pending -> IDLE.
REQ-024 A grant SHALL end on m_ack = 1 (last updates to the granted port) or on the granted req = 0 (withdrawal; last unchanged).
REQ-025 When a grant ends, the next state SHALL be chosen per REQ-023 from the other port's request only; the just-served port SHALL NOT be regranted in that same cycle.
REQ-026 In a grant, state SHALL remain GNT_X while X_req = 1 and m_ack = 0, with no time limit.
REQ-027 Arbitration latency: a request arriving in IDLE SHALL see m_req asserted on the following cycle; back-to-back alternating grants SHALL have zero idle cycles.
REQ-028 Requesters SHALL hold address and attributes stable while req = 1; the block does not register them.

Reset
REQ-029 While reset = 1, state SHALL become IDLE and last SHALL become 0 at the next edge, aborting any grant in progress.
REQ-030 During and after reset, m_req, i_ack, and d_ack SHALL be 0 until a new grant is taken.

Verification
REQ-031 Fetch only, i_addr = 0x100, m_ack on the 2nd grant cycle -> m_req rises 1 cycle after i_req, m_addr = 0x100, m_width = 2, i_ack = 1 for 1 cycle, i_rdata = m_rdata, d_ack = 0.
REQ-032 i_req and d_req rise together after reset -> data is granted first (last = 0); on its m_ack, the next cycle is GNT_I with m_addr = i_addr and no idle cycle.
REQ-033 Store d_addr = 0x2003, d_wdata = 0xAB, d_width = 0, d_write = 1 -> m_write = 1, m_width = 0, m_wdata = 0xAB; no i_ack is asserted.
REQ-034 Both ports request continuously, m_ack every cycle -> grants alternate D, I, D, I, with each port acked on alternating cycles.
REQ-035 In GNT_I, i_req drops before m_ack (flush) while d_req = 1 -> m_req = 0 that cycle, next state is GNT_D, and last remains 0.
REQ-036 reset asserted mid-GNT_D with d_req held -> next cycle IDLE and m_req = 0; after release, d is regranted 1 cycle later.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// Grants are combinationally forwarded; only state and last are registered.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_write,
  input  logic        d_extend,
  input  logic [1:0]  d_width,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_write,
  output logic        m_extend,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_width,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   gnt_i, gnt_d;

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

  // A finished grant may only hand over to the other port, never regrant.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = last_q ? GNT_I : GNT_D;
        else if (i_req)     state_d = GNT_I;
        else if (d_req)     state_d = GNT_D;
        else                state_d = IDLE;
      end
      GNT_I: begin
        if (m_ack || !i_req) begin
          if (m_ack) last_d = 1'b0;
          state_d = d_req ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (m_ack || !d_req) begin
          if (m_ack) last_d = 1'b1;
          state_d = i_req ? GNT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign m_req    = (gnt_i & i_req) | (gnt_d & d_req);
  assign i_ack    = gnt_i & m_ack;
  assign d_ack    = gnt_d & m_ack;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  assign m_addr   = gnt_d ? d_addr   : i_addr;
  assign m_wdata  = gnt_d ? d_wdata  : 32'd0;
  assign m_write  = gnt_d & d_write;
  assign m_extend = gnt_d & d_extend;
  assign m_width  = gnt_d ? d_width  : 2'b10;

endmodule
